// File: rtl/fp_mul_scheduler_pkg.sv
// Shared floating-point helpers: exponent bias and requester-id width.
package fp_mul_scheduler_pkg;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FP_BIAS_SP = fp_bias(8);

endpackage

// File: rtl/fp_mul_scheduler_mul.sv
// Combinational FP multiplier: sign XOR, biased exponent add, one-bit normalise,
// truncated mantissa, flush to zero when either operand is exactly zero.
module floating_point_mul
    import fp_mul_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
)(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] p_o
);

    localparam logic [E+1:0] BIAS = (E+2)'(fp_bias(E));

    logic [E-1:0]     ea, eb;
    logic [M:0]       ma, mb;
    logic [2*M+1:0]   prod;
    logic [E+1:0]     exp_sum;
    logic [M-1:0]     frac;
    logic             zero;
    logic             sign;

    // Product of two [1,2) mantissas lies in [1,4); a set top bit means shift by one.
    function automatic logic [M-1:0] trunc_frac(input logic [2*M+1:0] p);
        return p[2*M+1] ? p[2*M -: M] : p[2*M-1 -: M];
    endfunction

    assign ea      = a_i[DATA_WIDTH-2 -: E];
    assign eb      = b_i[DATA_WIDTH-2 -: E];
    assign ma      = {1'b1, a_i[M-1:0]};
    assign mb      = {1'b1, b_i[M-1:0]};
    assign sign    = a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1];
    assign zero    = (a_i[DATA_WIDTH-2:0] == '0) || (b_i[DATA_WIDTH-2:0] == '0);
    assign prod    = {{(M+1){1'b0}}, ma} * {{(M+1){1'b0}}, mb};
    assign frac    = trunc_frac(prod);
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS + {{(E+1){1'b0}}, prod[2*M+1]};
    assign p_o     = zero ? '0 : {sign, exp_sum[E-1:0], frac};

endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one FP multiplier among N_REQ requesters
// through an operand stage (p1) and a result stage (p2).
module fp_mul_scheduler
    import fp_mul_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int N_REQ      = 4,
    localparam int ID_W      = fp_id_width(N_REQ)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic [15:0]                 ops_done
);

    localparam logic [ID_W:0] N_X = (ID_W+1)'(N_REQ);

    logic                  vld_p1_q, vld_p1_d;
    logic [DATA_WIDTH-1:0] a_p1_q, a_p1_d;
    logic [DATA_WIDTH-1:0] b_p1_q, b_p1_d;
    logic [ID_W-1:0]       id_p1_q, id_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
    logic [ID_W-1:0]       id_p2_q, id_p2_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]           ops_q, ops_d;

    logic                  s1_adv, s2_adv, accept, rsp_hs;
    logic                  gnt_found;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W:0]         cand;
    logic [DATA_WIDTH-1:0] prod_p1;

    assign s2_adv = !vld_p2_q || rsp_ready;
    assign s1_adv = !vld_p1_q || s2_adv;
    assign rsp_hs = vld_p2_q && rsp_ready;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= N_X) cand = cand - N_X;
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept    = s1_adv && gnt_found && rst_n;
    assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

    // Stage p1: capture the winning operand pair.
    always_comb begin
        vld_p1_d = vld_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        id_p1_d  = id_p1_q;
        rr_ptr_d = rr_ptr_q;
        if (s1_adv) vld_p1_d = accept;
        if (accept) begin
            a_p1_d   = req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            b_p1_d   = req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            id_p1_d  = gnt_idx;
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    floating_point_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .E          (E),
        .M          (M)
    ) u_mul (
        .a_i (a_p1_q),
        .b_i (b_p1_q),
        .p_o (prod_p1)
    );

    // Stage p2: result register, held while downstream stalls.
    always_comb begin
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        id_p2_d   = id_p2_q;
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                data_p2_d = prod_p1;
                id_p2_d   = id_p1_q;
            end
        end
        ops_d = ops_q + {15'd0, rsp_hs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            id_p2_q   <= '0;
            rr_ptr_q  <= '0;
            ops_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            id_p2_q   <= id_p2_d;
            rr_ptr_q  <= rr_ptr_d;
            ops_q     <= ops_d;
        end
    end

    always_ff @(posedge clk) begin
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
        id_p1_q <= id_p1_d;
    end

    assign rsp_valid = vld_p2_q;
    assign rsp_data  = data_p2_q;
    assign rsp_id    = id_p2_q;
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: reference model plus directed scenarios.
module tb_fp_mul_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic [15:0]     ops_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mul_scheduler #(
        .DATA_WIDTH (DW),
        .E          (8),
        .M          (23),
        .N_REQ      (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ops_done  (ops_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference product from the arithmetic rules, using wide integers.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, p;
        int e;
        if (a[30:0] == 0 || b[30:0] == 0) return 32'h0;
        ma = (64'd1 << 23) | 64'(a[22:0]);
        mb = (64'd1 << 23) | 64'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
            e = e + 1;
            p = p >> 1;
        end
        return {a[31] ^ b[31], 8'(e), 23'(p >> 23)};
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    logic [31:0] exp_d[$];
    int          exp_id[$];
    int          m_rr = 0;
    logic [15:0] m_ops = 16'd0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_d;
    logic [1:0]  prev_id;

    always @(negedge clk) begin
        int g;
        if (!rst_n) begin
            exp_d.delete();
            exp_id.delete();
            m_rr = 0;
            m_ops = 16'd0;
            stall_prev = 1'b0;
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_ops_done", 64'(ops_done), 64'd0);
        end else begin
            check("ops_done", 64'(ops_done), 64'(m_ops));
            if (stall_prev) begin
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_data", 64'(rsp_data), 64'(prev_d));
                check("hold_id", 64'(rsp_id), 64'(prev_id));
            end
            if (rsp_valid) begin
                if (exp_d.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(exp_d[0]));
                    check("rsp_id", 64'(rsp_id), 64'(exp_id[0]));
                    if (rsp_ready) begin
                        void'(exp_d.pop_front());
                        void'(exp_id.pop_front());
                        m_ops = m_ops + 16'd1;
                    end
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_d = rsp_data;
            prev_id = rsp_id;
            check("rdy_subset", 64'(req_ready & ~req_valid), 64'd0);
            if (req_ready != '0) begin
                g = model_grant(req_valid, m_rr);
                check("rr_grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
                if (g >= 0) begin
                    exp_d.push_back(model_mul(req_a[g*DW +: DW], req_b[g*DW +: DW]));
                    exp_id.push_back(g);
                    m_rr = (g + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        #1 check("rst_now_ready", 64'(req_ready), 64'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        int cyc;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;

        check("pin_mul_1x2", 64'(model_mul(32'h3F800000, 32'h40000000)), 64'h40000000);
        check("pin_mul_15x15", 64'(model_mul(32'h3FC00000, 32'h3FC00000)), 64'h40100000);
        check("pin_mul_m2x3", 64'(model_mul(32'hC0000000, 32'h40400000)), 64'hC0C00000);
        check("pin_mul_zero", 64'(model_mul(32'h00000000, 32'h40490FDB)), 64'h0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, two-cycle latency.
        set_req(0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        #1 check("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        #1 check("t1_lat1", 64'(rsp_valid), 64'd0);
        step();
        #1 check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_data", 64'(rsp_data), 64'h40000000);
        check("t1_id", 64'(rsp_id), 64'd0);
        check("t1_ops0", 64'(ops_done), 64'd0);
        step();
        #1 check("t1_ops1", 64'(ops_done), 64'd1);
        check("t1_empty", 64'(rsp_valid), 64'd0);

        // All requesters streaming: rotation 0,1,2,3 and one result per cycle.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1 check("t2_grant", 64'(req_ready), 64'd1 << (k % 4));
            if (k >= 2) begin
                check("t2_valid", 64'(rsp_valid), 64'd1);
                check("t2_data", 64'(rsp_data), 64'h40100000);
                check("t2_id", 64'(rsp_id), 64'((k - 2) % 4));
            end
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure with both stages full.
        rsp_ready = 1'b0;
        set_req(2, 32'hC0000000, 32'h40400000);
        req_valid = 4'b0100;
        #1 check("t3_rdy_first", 64'(req_ready), 64'h4);
        step();
        #1 check("t3_rdy_second", 64'(req_ready), 64'h4);
        step();
        for (int k = 0; k < 5; k++) begin
            #1 check("t3_stall_rdy", 64'(req_ready), 64'd0);
            check("t3_stall_valid", 64'(rsp_valid), 64'd1);
            check("t3_stall_data", 64'(rsp_data), 64'hC0C00000);
            check("t3_stall_id", 64'(rsp_id), 64'd2);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1 check("t3_rel1", 64'(rsp_data), 64'hC0C00000);
        step();
        #1 check("t3_rel2_valid", 64'(rsp_valid), 64'd1);
        check("t3_rel2_data", 64'(rsp_data), 64'hC0C00000);
        step();
        #1 check("t3_done", 64'(rsp_valid), 64'd0);

        // Zero operand flushes the product.
        set_req(3, 32'h00000000, 32'h40490FDB);
        req_valid = 4'b1000;
        #1 check("t4_ready", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        step();
        #1 check("t4_valid", 64'(rsp_valid), 64'd1);
        check("t4_data", 64'(rsp_data), 64'h0);
        check("t4_id", 64'(rsp_id), 64'd3);
        step();

        // Reset with both stages occupied.
        rsp_ready = 1'b0;
        set_req(0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        step();
        step();
        #1 check("t5_full", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1 check("t5_rst_valid", 64'(rsp_valid), 64'd0);
        check("t5_rst_ops", 64'(ops_done), 64'd0);
        check("t5_rst_ready", 64'(req_ready), 64'd0);
        step();
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("t5_no_stale", 64'(rsp_valid), 64'd0);
            step();
        end
        for (int i = 0; i < N; i++) set_req(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b1111;
        #1 check("t5_rr_zero", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        repeat (4) step();

        // ops_done wrap after 65536 results.
        do_reset();
        set_req(0, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b0001;
        hs = 0;
        cyc = 0;
        while (hs < 65536 && cyc < 70000) begin
            #1;
            if (rsp_valid && rsp_ready) begin
                hs++;
                if (hs == 65536) check("t6_pre_wrap", 64'(ops_done), 64'hFFFF);
            end
            step();
            cyc++;
        end
        req_valid = '0;
        #1 check("t6_bound", 64'(hs), 64'd65536);
        check("t6_wrap", 64'(ops_done), 64'h0);
        repeat (4) step();
        check("model_drained", 64'(exp_d.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
